arb_bus: RTL and testbench
==========================

ARB_BUS -- requirements
Module: arb_bus

Interface
REQ-001 Parameter Bus_length, default 4, number of source channels (N, 2..32).
REQ-002 Parameter Bus_width, default 32, data width in bits (W).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  N  per-source request; held high with stable data until that source's gnt.
REQ-006 data_lines  input  N x W signed  per-source data, packed [N-1:0][W-1:0].
REQ-007 mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-008 out_ready  input  1  consumer accepts bus_out when high with bus_valid.
REQ-009 gnt  output  N  registered one-hot one-cycle pulse: winner's data captured at the preceding edge.
REQ-010 bus_out  output  W signed  registered selected data; replaces the tri-state bus.
REQ-011 bus_valid  output  1  bus_out holds unconsumed data.
REQ-012 src_id  output  clog2(N)  index of the source currently on bus_out.

Function
REQ-013 States: IDLE (bus_valid=0) and DRIVE (bus_valid=1); no other states.
REQ-014 Capture condition: (IDLE, or DRIVE with out_ready) and at least one eligible request.
REQ-015 Eligible = req AND NOT gnt; the source pulsed in the current cycle never wins again that cycle.
REQ-016 On capture: bus_out <= data_lines[winner], src_id <= winner, gnt <= onehot(winner), state <= DRIVE, all at the same edge.
REQ-017 Latency: req sampled at cycle t; bus_valid, bus_out and gnt first visible at t+1.
REQ-018 Round-robin: search starts at ptr+1 modulo N and wraps; ptr <= winner on each capture.
REQ-019 Fixed priority: lowest eligible index wins; ptr is still updated.
REQ-020 DRIVE with out_ready and no eligible request: state <= IDLE, bus_valid <= 0, bus_out and src_id hold.
REQ-021 DRIVE without out_ready: bus_out, src_id and bus_valid hold; gnt = 0; no capture.
REQ-022 Back-to-back: DRIVE with out_ready and an eligible request recaptures; bus_valid stays 1 with no bubble.
REQ-023 gnt is zero in every cycle not immediately following a capture.
REQ-024 mode is sampled at each capture; a change takes effect at the next capture.
REQ-025 Data and req of non-winning sources have no effect on outputs.

Reset
REQ-026 While reset is high at an edge: state <= IDLE, bus_valid <= 0, gnt <= 0, bus_out <= 0, src_id <= 0, ptr <= N-1 (source 0 first).
REQ-027 Reset mid-DRIVE discards held data; no gnt is issued in the cycle after reset.
REQ-028 Reset has priority over any simultaneous capture.

Structure
REQ-029 Shared package bus_pkg holds the state enum (IDLE, DRIVE) and default Bus_length/Bus_width constants.
REQ-030 Sub-module rr_pick: combinational N-bit picker taking eligible, ptr and mode, returning a one-hot winner and index.
REQ-031 arb_bus holds all registers and the output mux; no tri-state drivers anywhere.

Verification (N=4, W=32)
REQ-032 Reset, then req=0001, data_lines[0]='b1101, out_ready=1 -> next cycle bus_out=13, src_id=0, gnt=0001, bus_valid=1; then IDLE after req drops.
REQ-033 mode=0, req=1111 held, out_ready=1, data 13/3/2432/31123 -> src_id sequence 0,1,2,3,0; bus_valid continuously 1.
REQ-034 mode=1, same stimulus -> winners alternate 0 (gnt cycle masks it), 1, 0, 1; sources 2 and 3 never granted.
REQ-035 Capture 2432 from source 2, out_ready=0 for 5 cycles while req=1011 -> bus_out=2432 stable, gnt=0; first out_ready -> source 3 captured (31123).
REQ-036 Reset asserted during DRIVE with bus_out=31123 -> next cycle bus_valid=0, bus_out=0, gnt=0; next capture with req=1111 picks source 0.
REQ-037 Single source req=0100 held 3 cycles, out_ready=1 -> gnt=0100 on alternate cycles only; never two consecutive pulses.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default sizing for the arbitrated source bus.
package bus_pkg;
   typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} bus_state_t;

   localparam int BUS_LENGTH_DEF = 4;
   localparam int BUS_WIDTH_DEF  = 32;
endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: round-robin after ptr, or lowest-index-first.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   input  logic          mode,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          found
);

   always_comb begin
      int j;
      j      = 0;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      // Scan from the far end so the last hit written is the preferred one.
      if (mode) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
               idx   = IW'(i);
               found = 1'b1;
            end
         end
      end else begin
         for (int k = N; k >= 1; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (eligible[j]) begin
               idx   = IW'(j);
               found = 1'b1;
            end
         end
      end
      if (found) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/arb_bus.sv
// N-source arbitrated bus: registered winner data, one-cycle grant pulse,
// valid/ready hand-off to a single consumer.
module arb_bus
   import bus_pkg::*;
#(
   parameter int Bus_length = BUS_LENGTH_DEF,
   parameter int Bus_width  = BUS_WIDTH_DEF,
   localparam int IW = (Bus_length > 1) ? $clog2(Bus_length) : 1
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic        [Bus_length-1:0]              req,
   input  logic signed [Bus_length-1:0][Bus_width-1:0] data_lines,
   input  logic                                      mode,
   input  logic                                      out_ready,
   output logic        [Bus_length-1:0]              gnt,
   output logic signed [Bus_width-1:0]               bus_out,
   output logic                                      bus_valid,
   output logic        [IW-1:0]                      src_id
);

   bus_state_t            state, state_nxt;
   logic [IW-1:0]         ptr;
   logic [Bus_length-1:0] eligible, win_oh;
   logic [IW-1:0]         win_idx;
   logic                  win_found;
   logic                  capture;

   // The source granted last cycle is still holding req; mask it out.
   assign eligible = req & ~gnt;

   rr_pick #(.N(Bus_length), .IW(IW)) u_pick (
      .eligible (eligible),
      .ptr      (ptr),
      .mode     (mode),
      .onehot   (win_oh),
      .idx      (win_idx),
      .found    (win_found)
   );

   assign capture   = ((state == IDLE) || out_ready) && win_found;
   assign bus_valid = (state == DRIVE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (capture) state_nxt = DRIVE;
         DRIVE:   if (!capture && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         gnt     <= '0;
         bus_out <= '0;
         src_id  <= '0;
         ptr     <= IW'(Bus_length - 1);
      end else begin
         state <= state_nxt;
         gnt   <= capture ? win_oh : '0;
         if (capture) begin
            bus_out <= data_lines[win_idx];
            src_id  <= win_idx;
            ptr     <= win_idx;
         end
      end
   end

endmodule

// File: tb/tb_arb_bus.sv
// Directed bench for arb_bus with a cycle-level reference model and literal pins.
module tb_arb_bus;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int IW = 2;

   logic                      clk = 1'b0;
   logic                      reset;
   logic        [N-1:0]       req;
   logic signed [N-1:0][W-1:0] data_lines;
   logic                      mode;
   logic                      out_ready;
   logic        [N-1:0]       gnt;
   logic signed [W-1:0]       bus_out;
   logic                      bus_valid;
   logic        [IW-1:0]      src_id;

   int checks = 0;
   int errors = 0;

   arb_bus #(.Bus_length(N), .Bus_width(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .data_lines (data_lines),
      .mode       (mode),
      .out_ready  (out_ready),
      .gnt        (gnt),
      .bus_out    (bus_out),
      .bus_valid  (bus_valid),
      .src_id     (src_id)
   );

   always #5 clk = ~clk;

   // Reference model: what the bus must present after each edge.
   int  m_valid = 0;
   int  m_gnt   = 0;
   int  m_out   = 0;
   int  m_id    = 0;
   int  m_ptr   = N - 1;
   int  prev_gnt = 0;

   always @(posedge clk) begin
      int elig, w, c;
      if (reset) begin
         m_valid = 0; m_gnt = 0; m_out = 0; m_id = 0; m_ptr = N - 1;
      end else begin
         elig = int'(req) & ~m_gnt;
         w = -1;
         if (elig != 0 && (m_valid == 0 || out_ready)) begin
            if (mode) begin
               for (int i = 0; i < N && w < 0; i++) if (elig[i]) w = i;
            end else begin
               for (int k = 1; k <= N && w < 0; k++) begin
                  c = (m_ptr + k) % N;
                  if (elig[c]) w = c;
               end
            end
         end
         if (w >= 0) begin
            m_out = int'(data_lines[w]); m_id = w; m_gnt = 1 << w;
            m_valid = 1; m_ptr = w;
         end else begin
            m_gnt = 0;
            if (m_valid == 1 && out_ready) m_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (bus_valid !== 1'(m_valid) || gnt !== N'(m_gnt) ||
          bus_out !== W'(m_out) || src_id !== IW'(m_id)) begin
         errors++;
         $display("FAIL model t=%0t: valid=%0d gnt=%b out=%0d id=%0d required valid=%0d gnt=%b out=%0d id=%0d",
                  $time, bus_valid, gnt, bus_out, src_id, m_valid, N'(m_gnt), m_out, m_id);
      end
      checks++;
      if ((gnt & N'(prev_gnt)) != 0) begin
         errors++;
         $display("FAIL gnt_repeat t=%0t: gnt=%b prev=%b", $time, gnt, N'(prev_gnt));
      end
      prev_gnt = int'(gnt);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int exp_rr[5];
      int exp_fp[4];
      exp_rr = '{0, 1, 2, 3, 0};
      exp_fp = '{0, 1, 0, 1};
      reset = 1'b1; req = '0; mode = 1'b0; out_ready = 1'b1;
      data_lines[0] = 13; data_lines[1] = 3; data_lines[2] = 2432; data_lines[3] = 31123;
      #1;
      do_reset();
      chk("reset_valid", int'(bus_valid), 0);
      chk("reset_gnt", int'(gnt), 0);
      chk("reset_out", int'(bus_out), 0);

      // Single capture then return to idle
      data_lines[0] = 'b1101;
      req = 4'b0001;
      step();
      chk("single_out", int'(bus_out), 13);
      chk("single_id", int'(src_id), 0);
      chk("single_gnt", int'(gnt), 1);
      chk("single_valid", int'(bus_valid), 1);
      req = '0;
      step();
      chk("single_idle", int'(bus_valid), 0);
      chk("single_gnt_clr", int'(gnt), 0);

      // Round-robin rotation
      do_reset();
      mode = 1'b0; req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("rr_id%0d", i), int'(src_id), exp_rr[i]);
         chk($sformatf("rr_valid%0d", i), int'(bus_valid), 1);
      end
      chk("rr_last_out", int'(bus_out), 13);

      // Fixed priority alternates between 0 and 1
      do_reset();
      mode = 1'b1; req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("fp_id%0d", i), int'(src_id), exp_fp[i]);
         chk($sformatf("fp_gnt%0d", i), int'(gnt), 1 << exp_fp[i]);
      end

      // Back-pressure holds the bus, then source 3 is next in rotation
      do_reset();
      mode = 1'b0; req = 4'b0100; out_ready = 1'b1;
      step();
      chk("bp_cap", int'(bus_out), 2432);
      req = 4'b1011; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_hold%0d", i), int'(bus_out), 2432);
         chk($sformatf("bp_gnt%0d", i), int'(gnt), 0);
      end
      out_ready = 1'b1;
      step();
      chk("bp_next_id", int'(src_id), 3);
      chk("bp_next_out", int'(bus_out), 31123);

      // Reset mid-drive
      reset = 1'b1;
      step();
      chk("mid_rst_valid", int'(bus_valid), 0);
      chk("mid_rst_out", int'(bus_out), 0);
      chk("mid_rst_gnt", int'(gnt), 0);
      reset = 1'b0; req = 4'b1111;
      step();
      chk("post_rst_id", int'(src_id), 0);

      // Lone requester is granted only on alternate cycles
      do_reset();
      req = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("lone_gnt%0d", i), int'(gnt), (i % 2 == 0) ? 4 : 0);
      end

      // Mixed traffic with mode and ready toggling, checked by the model
      req = '0;
      for (int i = 0; i < 60; i++) begin
         req = 4'($urandom_range(0, 15));
         mode = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         data_lines[$urandom_range(0, N - 1)] = W'($urandom);
         step();
      end

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
